mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Multi-cycle memory-access stage between Execution and Write Back, for a variable-latency data memory in place of the single-cycle Memory stage. Accepts one Execution bundle at a time, runs a request/acknowledge transaction on the data-memory port for loads and stores, and stalls upstream until it completes. Resolves the branch decision (`PC_SRC`) and passes the result bundle to Write Back.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles waiting for `dmem_ack` before abort (used only with the timeout feature).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `valid_receive` in 1: Execution bundle valid.
- `Result_receive` in 64: ALU result; the byte address for memory ops.
- `read_data_2_receive` in 64: store data.
- `rd_receive` in 5: destination register.
- `Mem_Read_receive`, `Mem_Write_receive`, `Mem_to_Reg_receive`, `regWrite_receive`, `Branch_receive`, `Zero_receive` in 1 each: control from Execution.
- `pcbranch_receive` in 64: branch target.
- `stall` out 1: upstream must hold its bundle.
- `valid` out 1: Write Back bundle valid, one-cycle pulse.
- `Result`, `ReadData` out 64: registered ALU result and load data.
- `rd` out 5; `regWrite`, `Mem_to_Reg` out 1: registered to Write Back.
- `PC_SRC` out 1; `pcbranch` out 64: branch redirect to Instruction Fetch.
- `mem_fault` out 1: one-cycle pulse on an illegal or aborted access.
- `dmem_req`, `dmem_we` out 1; `dmem_addr`, `dmem_wdata` out 64: data-memory request, all registered.
- `dmem_ack` in 1; `dmem_rdata` in 64: completion strobe and load data, sampled when `dmem_ack`=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE, `valid_receive`=0:** nothing happens.
- **IDLE, `valid_receive`=1, no memory op** (`Mem_Read`=`Mem_Write`=0): capture the bundle and go to DONE.
- **IDLE, `valid_receive`=1, memory op:**
  - Capture the bundle.
  - Drive `dmem_req`=1, `dmem_addr`=`Result_receive`, `dmem_we`=`Mem_Write_receive`, `dmem_wdata`=`read_data_2_receive`.
  - Go to BUSY.
- **BUSY:**
  - Hold `dmem_req` and its operands constant until `dmem_ack`.
  - On `dmem_ack`: drop `dmem_req`, latch `dmem_rdata` into `ReadData` (loads only; stores leave `ReadData`=0), go to DONE.
- **DONE:** assert `valid` for one cycle with the captured bundle, then go to IDLE.
- **Illegal access** — both `Mem_Read_receive` and `Mem_Write_receive`=1, or a memory op with address[2:0]≠0 (misaligned doubleword):
  - No request is issued.
  - Go to DONE with `regWrite` forced to 0 and `mem_fault` pulsed in the DONE cycle.
- **Branch:**
  - `PC_SRC` = `Branch_receive & Zero_receive` as captured.
  - `PC_SRC` is asserted only in the DONE cycle; otherwise 0.
  - `pcbranch` holds the captured target.
- **`stall`:**
  - Combinational: 1 in BUSY and DONE.
  - 1 in IDLE when accepting a memory op.
  - 0 otherwise.
- A `dmem_ack` arriving in IDLE or DONE is ignored.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE. A reset mid-transaction drops `dmem_req` immediately and discards the bundle; no `valid` follows.
- **Non-memory bundle:** accepted at edge N, `valid` high in cycle N+1.
- **Memory bundle:**
  - Accepted at edge N; `dmem_req` high from cycle N+1.
  - If `dmem_ack` is sampled at edge M, `valid` and `ReadData` appear in cycle M+1.
  - Minimum latency 2 cycles (ack in the first request cycle).
- **Throughput:** at most one bundle per 2 cycles, because DONE always stalls.
- `ReadData` and `Result` hold their values until the next DONE.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - A counter runs in BUSY, cleared on entry.
  - When it reaches `TIMEOUT_CYCLES` without ack: drop `dmem_req`, go to DONE with `regWrite`=0, `ReadData`=0, `mem_fault`=1.
  - An ack in the same cycle as expiry wins over the timeout.
- Undefined: BUSY waits indefinitely. The counter and `TIMEOUT_CYCLES` logic are absent.

## Structure
- Shared package `riscv_pkg`: FSM state enum, `XLEN`=64, `REG_ADDR_W`=5, the Execution-to-Memory bundle struct.
- One sub-module, `mem_timeout_counter` (enable, clear, expired); instantiated only under `MEM_ACCESS_TIMEOUT_EN`.

## Test plan
- **ALU op:** `valid_receive`=1, `Result_receive`=5, `regWrite_receive`=1, no memory op → `valid`=1 next cycle, `Result`=5, `regWrite`=1, `dmem_req` never asserted.
- **Load with delayed ack:** `Mem_Read`=1, addr=0x10, ack 3 cycles after req with `dmem_rdata`=0xDEAD → `stall` high 5 cycles, then `valid`=1, `ReadData`=0xDEAD, `Mem_to_Reg` passed through.
- **Store:** addr=0x18, data=0x7, immediate ack → `dmem_we`=1, `dmem_wdata`=0x7 for one cycle, `valid` 2 cycles after accept, `ReadData`=0.
- **Taken branch:** `Branch`=1, `Zero`=1, `pcbranch_receive`=12 → `PC_SRC`=1 and `pcbranch`=12 in the `valid` cycle only. Repeat with `Zero`=0 → `PC_SRC` stays 0.
- **Faults:** misaligned addr=0x13, and separately Read+Write both set → no `dmem_req`, `mem_fault` pulse, `regWrite`=0. With `MEM_ACCESS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → abort after 4 BUSY cycles with `mem_fault`=1.
- **Reset mid-transaction:** assert `reset`=0 in BUSY → `dmem_req`, `stall`, `valid` drop asynchronously. A late ack after release causes no `valid`.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the memory-access stage.
//   - mem_state_t     : IDLE / BUSY / DONE controller states
//   - XLEN, REG_ADDR_W: datapath and register-index widths
//   - ex_mem_bundle_t : bundle handed over by Execution
//   - wb_bundle_t     : subset of the bundle kept for Write Back
//   - is_illegal_access(): read+write together, or a misaligned doubleword
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  branch;
    logic                  zero;
    logic [XLEN-1:0]       pcbranch;
  } ex_mem_bundle_t;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  pc_src;
    logic [XLEN-1:0]       pcbranch;
  } wb_bundle_t;

  // Memory ops must be doubleword aligned, and a bundle may not both read and write.
  function automatic logic is_illegal_access(input ex_mem_bundle_t b);
    return (b.mem_read & b.mem_write) |
           ((b.mem_read | b.mem_write) & (|b.result[2:0]));
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts cycles while a data-memory request waits for its ack.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   enable  : count this cycle (controller is waiting)
//   clear   : restart from zero (a new request is being launched)
//   expired : high during the LIMIT-th enabled cycle since the last clear
module mem_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] count_reg;

  // Expiry is flagged in the last waiting cycle so the controller leaves
  // after exactly LIMIT cycles of waiting.
  assign expired = enable && (count_reg == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: multi-cycle memory stage between Execution and Write Back
// for a variable-latency data memory.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a request that has
// not been acknowledged within TIMEOUT_CYCLES waiting cycles.
//
// Ports
//   clk, reset              : clock, asynchronous active-low reset
//   valid_receive + *_receive: Execution bundle (address in Result_receive)
//   stall                   : upstream must hold its bundle
//   valid                   : one-cycle Write Back strobe
//   Result, ReadData, rd, regWrite, Mem_to_Reg : registered Write Back bundle
//   PC_SRC, pcbranch        : branch redirect (PC_SRC only in the valid cycle)
//   mem_fault               : one-cycle pulse on an illegal or aborted access
//   dmem_req/we/addr/wdata  : registered data-memory request
//   dmem_ack, dmem_rdata    : memory completion strobe and load data
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_receive,
  input  logic [XLEN-1:0]       Result_receive,
  input  logic [XLEN-1:0]       read_data_2_receive,
  input  logic [REG_ADDR_W-1:0] rd_receive,
  input  logic                  Mem_Read_receive,
  input  logic                  Mem_Write_receive,
  input  logic                  Mem_to_Reg_receive,
  input  logic                  regWrite_receive,
  input  logic                  Branch_receive,
  input  logic                  Zero_receive,
  input  logic [XLEN-1:0]       pcbranch_receive,
  output logic                  stall,
  output logic                  valid,
  output logic [XLEN-1:0]       Result,
  output logic [XLEN-1:0]       ReadData,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  regWrite,
  output logic                  Mem_to_Reg,
  output logic                  PC_SRC,
  output logic [XLEN-1:0]       pcbranch,
  output logic                  mem_fault,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata
);

  mem_state_t     state_reg, state_next;
  ex_mem_bundle_t in_bundle;
  wb_bundle_t     in_wb, cap_reg, wb_src;
  logic           cap_is_load_reg;
  logic           in_is_mem, in_illegal;
  logic           accept_mem, accept_direct, finish_busy, abort;
  logic           timeout_expired;

  // Write Back registers
  logic [XLEN-1:0]       result_reg, read_data_reg, pcbranch_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic                  regwrite_reg, mem_to_reg_reg, pc_src_reg, fault_reg;
  logic                  wb_fault_next;
  logic [XLEN-1:0]       wb_rdata_next;

  // Memory request registers
  logic                  dmem_req_reg, dmem_we_reg;
  logic [XLEN-1:0]       dmem_addr_reg, dmem_wdata_reg;

  assign in_bundle = '{
    result:     Result_receive,
    store_data: read_data_2_receive,
    rd:         rd_receive,
    mem_read:   Mem_Read_receive,
    mem_write:  Mem_Write_receive,
    mem_to_reg: Mem_to_Reg_receive,
    reg_write:  regWrite_receive,
    branch:     Branch_receive,
    zero:       Zero_receive,
    pcbranch:   pcbranch_receive
  };

  assign in_is_mem  = in_bundle.mem_read | in_bundle.mem_write;
  assign in_illegal = is_illegal_access(in_bundle);

  assign in_wb = '{
    result:     in_bundle.result,
    rd:         in_bundle.rd,
    mem_to_reg: in_bundle.mem_to_reg,
    reg_write:  in_bundle.reg_write,
    pc_src:     in_bundle.branch & in_bundle.zero,
    pcbranch:   in_bundle.pcbranch
  };

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_reg == ST_BUSY),
    .clear   (accept_mem),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    accept_mem    = 1'b0;
    accept_direct = 1'b0;
    finish_busy   = 1'b0;
    abort         = 1'b0;
    stall         = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (valid_receive) begin
          stall = in_is_mem;
          // Illegal accesses never reach the memory; they go straight to DONE.
          if (in_is_mem && !in_illegal) begin
            accept_mem = 1'b1;
            state_next = ST_BUSY;
          end else begin
            accept_direct = 1'b1;
            state_next    = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        // An ack in the expiry cycle completes the access normally.
        if (dmem_ack) begin
          finish_busy = 1'b1;
          state_next  = ST_DONE;
        end else if (timeout_expired) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        stall      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- Write Back source selection ----------------
  always_comb begin
    wb_src        = accept_direct ? in_wb : cap_reg;
    wb_fault_next = accept_direct ? in_illegal : abort;
    wb_rdata_next = (finish_busy && cap_is_load_reg) ? dmem_rdata : '0;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_reg         <= '0;
      cap_is_load_reg <= 1'b0;
      dmem_req_reg    <= 1'b0;
      dmem_we_reg     <= 1'b0;
      dmem_addr_reg   <= '0;
      dmem_wdata_reg  <= '0;
      result_reg      <= '0;
      read_data_reg   <= '0;
      rd_reg          <= '0;
      regwrite_reg    <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      pc_src_reg      <= 1'b0;
      pcbranch_reg    <= '0;
      fault_reg       <= 1'b0;
    end else begin
      if (accept_mem) begin
        cap_reg         <= in_wb;
        cap_is_load_reg <= in_bundle.mem_read;
        dmem_req_reg    <= 1'b1;
        dmem_we_reg     <= in_bundle.mem_write;
        dmem_addr_reg   <= in_bundle.result;
        dmem_wdata_reg  <= in_bundle.store_data;
      end else if (finish_busy || abort) begin
        dmem_req_reg   <= 1'b0;
        dmem_we_reg    <= 1'b0;
        dmem_wdata_reg <= '0;
      end

      // Write Back registers only change on entry to DONE, so they hold
      // between bundles.
      if (accept_direct || finish_busy || abort) begin
        result_reg     <= wb_src.result;
        rd_reg         <= wb_src.rd;
        mem_to_reg_reg <= wb_src.mem_to_reg;
        regwrite_reg   <= wb_src.reg_write & ~wb_fault_next;
        pc_src_reg     <= wb_src.pc_src;
        pcbranch_reg   <= wb_src.pcbranch;
        read_data_reg  <= wb_rdata_next;
        fault_reg      <= wb_fault_next;
      end
    end
  end

  assign valid      = (state_reg == ST_DONE);
  assign PC_SRC     = valid & pc_src_reg;
  assign mem_fault  = valid & fault_reg;
  assign Result     = result_reg;
  assign ReadData   = read_data_reg;
  assign rd         = rd_reg;
  assign regWrite   = regwrite_reg;
  assign Mem_to_Reg = mem_to_reg_reg;
  assign pcbranch   = pcbranch_reg;
  assign dmem_req   = dmem_req_reg;
  assign dmem_we    = dmem_we_reg;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
// Build with +define+MEM_ACCESS_TIMEOUT_EN to include the timeout cases.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_receive;
  logic [63:0] Result_receive, read_data_2_receive, pcbranch_receive;
  logic [4:0]  rd_receive;
  logic        Mem_Read_receive, Mem_Write_receive, Mem_to_Reg_receive;
  logic        regWrite_receive, Branch_receive, Zero_receive;
  logic        stall, valid, regWrite, Mem_to_Reg, PC_SRC, mem_fault;
  logic [63:0] Result, ReadData, pcbranch;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_receive       (valid_receive),
    .Result_receive      (Result_receive),
    .read_data_2_receive (read_data_2_receive),
    .rd_receive          (rd_receive),
    .Mem_Read_receive    (Mem_Read_receive),
    .Mem_Write_receive   (Mem_Write_receive),
    .Mem_to_Reg_receive  (Mem_to_Reg_receive),
    .regWrite_receive    (regWrite_receive),
    .Branch_receive      (Branch_receive),
    .Zero_receive        (Zero_receive),
    .pcbranch_receive    (pcbranch_receive),
    .stall               (stall),
    .valid               (valid),
    .Result              (Result),
    .ReadData            (ReadData),
    .rd                  (rd),
    .regWrite            (regWrite),
    .Mem_to_Reg          (Mem_to_Reg),
    .PC_SRC              (PC_SRC),
    .pcbranch            (pcbranch),
    .mem_fault           (mem_fault),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observations collected by run_txn
  int          stall_cnt, lat, req_cycles, we_cycles;
  logic [63:0] wdata_seen, addr_seen;
  bit          got_valid;

  task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic br, input logic z, input logic [63:0] res,
                       input logic [63:0] wd, input logic [63:0] pcb, input logic [4:0] rdv);
    valid_receive       = 1'b1;
    Mem_Read_receive    = mr;
    Mem_Write_receive   = mw;
    Mem_to_Reg_receive  = m2r;
    regWrite_receive    = rw;
    Branch_receive      = br;
    Zero_receive        = z;
    Result_receive      = res;
    read_data_2_receive = wd;
    pcbranch_receive    = pcb;
    rd_receive          = rdv;
  endtask

  // Bundle already driven just after a rising edge with the DUT idle.
  // Acks in the ack_after-th request cycle (0 = never). Returns at the
  // falling edge of the valid cycle, leaving the outputs there to be checked.
  task automatic run_txn(input int ack_after, input logic [63:0] rdata);
    stall_cnt = 0; lat = -1; req_cycles = 0; we_cycles = 0;
    wdata_seen = '0; addr_seen = '0; got_valid = 1'b0;
    dmem_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (valid) begin
        got_valid = 1'b1;
        lat = c;
        break;
      end
      if (dmem_req) begin
        req_cycles++;
        addr_seen = dmem_addr;
        if (dmem_we) begin
          we_cycles++;
          wdata_seen = dmem_wdata;
        end
      end
      dmem_ack = dmem_req && (req_cycles == ack_after);
      @(posedge clk); #1;
      valid_receive = 1'b0;
    end
    dmem_ack = 1'b0;
    valid_receive = 1'b0;
    if (!got_valid) chk("valid_never_seen", 64'(got_valid), 64'd1);
  endtask

  // Advance to the falling edge of the following cycle.
  task automatic next_cycle();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  int vcount;

  initial begin
    reset = 1'b0;
    valid_receive = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 5'd0);
    valid_receive = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_result", Result, 64'd0);
    chk("rst_readdata", ReadData, 64'd0);
    chk("rst_pc_src", 64'(PC_SRC), 64'd0);
    chk("rst_fault", 64'(mem_fault), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    $display("txn reset done");

    // ---- ALU op ----
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0, 64'd5, 64'd0, 64'd0, 5'd3);
    run_txn(0, 64'd0);
    chk("alu_latency", 64'(lat), 64'd1);
    chk("alu_stall_cycles", 64'(stall_cnt), 64'd1);
    chk("alu_result", Result, 64'd5);
    chk("alu_regwrite", 64'(regWrite), 64'd1);
    chk("alu_rd", 64'(rd), 64'd3);
    chk("alu_req_cycles", 64'(req_cycles), 64'd0);
    chk("alu_fault", 64'(mem_fault), 64'd0);
    next_cycle();
    chk("alu_valid_pulse", 64'(valid), 64'd0);
    $display("txn alu lat=%0d result=0x%0h", lat, Result);

    // ---- load with delayed ack ----
    @(posedge clk); #1;
    drive(1, 0, 1, 1, 0, 0, 64'h10, 64'd0, 64'd0, 5'd7);
    run_txn(3, 64'hDEAD);
    chk("ld_stall_cycles", 64'(stall_cnt), 64'd5);
    chk("ld_latency", 64'(lat), 64'd4);
    chk("ld_addr", addr_seen, 64'h10);
    chk("ld_we_cycles", 64'(we_cycles), 64'd0);
    chk("ld_readdata", ReadData, 64'hDEAD);
    chk("ld_mem_to_reg", 64'(Mem_to_Reg), 64'd1);
    chk("ld_regwrite", 64'(regWrite), 64'd1);
    chk("ld_rd", 64'(rd), 64'd7);
    chk("ld_result", Result, 64'h10);
    next_cycle();
    chk("ld_valid_pulse", 64'(valid), 64'd0);
    chk("ld_readdata_hold", ReadData, 64'hDEAD);
    chk("ld_stall_after", 64'(stall), 64'd0);
    $display("txn load lat=%0d readdata=0x%0h", lat, ReadData);

    // ---- store with immediate ack ----
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 0, 64'h18, 64'h7, 64'd0, 5'd0);
    run_txn(1, 64'hFFFF);
    chk("st_latency", 64'(lat), 64'd2);
    chk("st_we_cycles", 64'(we_cycles), 64'd1);
    chk("st_wdata", wdata_seen, 64'h7);
    chk("st_addr", addr_seen, 64'h18);
    chk("st_readdata", ReadData, 64'd0);
    chk("st_req_dropped", 64'(dmem_req), 64'd0);
    $display("txn store lat=%0d wdata=0x%0h", lat, wdata_seen);

    // ---- taken branch ----
    next_cycle();
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 64'd0, 64'd0, 64'd12, 5'd0);
    @(negedge clk);
    chk("br_pc_src_before", 64'(PC_SRC), 64'd0);
    @(posedge clk); #1;
    valid_receive = 1'b0;
    @(negedge clk);
    chk("br_valid", 64'(valid), 64'd1);
    chk("br_pc_src", 64'(PC_SRC), 64'd1);
    chk("br_pcbranch", pcbranch, 64'd12);
    next_cycle();
    chk("br_pc_src_after", 64'(PC_SRC), 64'd0);
    $display("txn branch taken pcbranch=0x%0h", pcbranch);

    // ---- not-taken branch ----
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 64'd0, 64'd0, 64'd40, 5'd0);
    run_txn(0, 64'd0);
    chk("bnt_pc_src", 64'(PC_SRC), 64'd0);
    chk("bnt_pcbranch", pcbranch, 64'd40);
    $display("txn branch not-taken");

    // ---- misaligned load ----
    next_cycle();
    @(posedge clk); #1;
    drive(1, 0, 1, 1, 0, 0, 64'h13, 64'd0, 64'd0, 5'd9);
    run_txn(1, 64'h1234);
    chk("mis_latency", 64'(lat), 64'd1);
    chk("mis_req_cycles", 64'(req_cycles), 64'd0);
    chk("mis_fault", 64'(mem_fault), 64'd1);
    chk("mis_regwrite", 64'(regWrite), 64'd0);
    next_cycle();
    chk("mis_fault_pulse", 64'(mem_fault), 64'd0);
    $display("txn misaligned fault");

    // ---- read and write together ----
    @(posedge clk); #1;
    drive(1, 1, 0, 1, 0, 0, 64'h20, 64'h5, 64'd0, 5'd4);
    run_txn(1, 64'h1234);
    chk("rw_req_cycles", 64'(req_cycles), 64'd0);
    chk("rw_fault", 64'(mem_fault), 64'd1);
    chk("rw_regwrite", 64'(regWrite), 64'd0);
    $display("txn read+write fault");

`ifdef MEM_ACCESS_TIMEOUT_EN
    // ---- timeout abort after 4 waiting cycles ----
    next_cycle();
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 0, 0, 64'h30, 64'd0, 64'd0, 5'd2);
    run_txn(0, 64'hBEEF);
    chk("to_req_cycles", 64'(req_cycles), 64'd4);
    chk("to_latency", 64'(lat), 64'd5);
    chk("to_fault", 64'(mem_fault), 64'd1);
    chk("to_regwrite", 64'(regWrite), 64'd0);
    chk("to_readdata", ReadData, 64'd0);
    chk("to_req_dropped", 64'(dmem_req), 64'd0);
    $display("txn timeout abort");

    // ---- ack in the expiry cycle wins ----
    next_cycle();
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 0, 0, 64'h38, 64'd0, 64'd0, 5'd2);
    run_txn(4, 64'hBEEF);
    chk("toack_fault", 64'(mem_fault), 64'd0);
    chk("toack_readdata", ReadData, 64'hBEEF);
    chk("toack_regwrite", 64'(regWrite), 64'd1);
    $display("txn ack at expiry");
`endif

    // ---- reset mid-transaction ----
    next_cycle();
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 0, 0, 64'h40, 64'd0, 64'd0, 5'd1);
    @(posedge clk); #1;
    valid_receive = 1'b0;
    @(negedge clk);
    chk("rm_req_busy", 64'(dmem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_req_drop", 64'(dmem_req), 64'd0);
    chk("rm_stall_drop", 64'(stall), 64'd0);
    chk("rm_valid_drop", 64'(valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 64'h5555;
    vcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid) vcount++;
      if (c == 1) dmem_ack = 1'b0;
    end
    chk("rm_no_valid", 64'(vcount), 64'd0);
    $display("txn reset mid-transaction");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
